// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Single-issue instruction fetch stage. Holds the program
//                counter, drives the instruction ROM address directly from
//                it and registers the returned word (with its address) for
//                decode. Supports start, stall, branch redirect and halt.
//                Optional RUN-cycle counter enabled by the macro
//                INSTR_FETCH_CYCLE_COUNT_EN (CycleCount is tied to 0 when
//                the macro is undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int PC_size = 16,
    parameter int DW      = 9
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [PC_size-1:0] StartAddr,
    input  logic               Stall,
    input  logic               Branch,
    input  logic [PC_size-1:0] Target,
    input  logic               Halt,
    output logic [PC_size-1:0] ReadAddress,
    input  logic [DW-1:0]      Instruction,
    output logic [DW-1:0]      InstrOut,
    output logic [PC_size-1:0] InstrPC,
    output logic               InstrValid,
    output logic               Busy,
    output logic               Done,
    output logic [31:0]        CycleCount
);

    localparam logic [PC_size-1:0] PC_ONE = {{(PC_size-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_size-1:0] pc_q,    pc_d;
    logic [DW-1:0]      instr_q, instr_d;
    logic [PC_size-1:0] ipc_q,   ipc_d;
    logic               valid_q, valid_d;
    logic               busy_q;
    logic               done_q;

    // Next-state decode: Halt beats Branch beats Stall while running;
    // control inputs other than Start are don't-care outside RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = StartAddr;
                    valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    // PC is frozen; the word fetched this cycle is dropped.
                    state_d = ST_HALTED;
                    valid_d = 1'b0;
                end else if (Branch) begin
                    // Wrong-path word is squashed: one bubble, output holds.
                    pc_d    = Target;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    instr_d = Instruction;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_ONE; // natural wrap at all-ones
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Fetch state and registered status outputs; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_HALTED);
        end
    end

    assign ReadAddress = pc_q;
    assign InstrOut    = instr_q;
    assign InstrPC     = ipc_q;
    assign InstrValid  = valid_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

`ifdef INSTR_FETCH_CYCLE_COUNT_EN
    logic [31:0] cnt_q;

    // Count every cycle spent in RUN (stalls and bubbles included); clear on
    // an accepted Start and stick at all-ones.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if ((state_q != ST_RUN) && Start) begin
            cnt_q <= '0;
        end else if ((state_q == ST_RUN) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign CycleCount = cnt_q;
`else
    assign CycleCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch. Honours the
//                INSTR_FETCH_CYCLE_COUNT_EN macro for the counter expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [15:0] StartAddr;
    logic        Stall;
    logic        Branch;
    logic [15:0] Target;
    logic        Halt;
    logic [15:0] ReadAddress;
    logic [8:0]  Instruction;
    logic [8:0]  InstrOut;
    logic [15:0] InstrPC;
    logic        InstrValid;
    logic        Busy;
    logic        Done;
    logic [31:0] CycleCount;

    int n_chk  = 0;
    int n_pass = 0;

    instr_fetch #(.PC_size(16), .DW(9)) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Branch     (Branch),
        .Target     (Target),
        .Halt       (Halt),
        .ReadAddress(ReadAddress),
        .Instruction(Instruction),
        .InstrOut   (InstrOut),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .Busy       (Busy),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    always #5 CLK = ~CLK;

    // ROM contents: 0x10..0x12 hold 1,2,3; everything else is a fixed scramble.
    function automatic logic [8:0] rom(input logic [15:0] a);
        if (a >= 16'h0010 && a <= 16'h0012) rom = 9'(a - 16'h000F);
        else                                 rom = a[8:0] ^ 9'h155;
    endfunction

    always_comb Instruction = rom(ReadAddress);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Start = 1'b0; Stall = 1'b0; Branch = 1'b0; Halt = 1'b0;
    endtask

    logic [31:0] exp_cnt10;

    initial begin
`ifdef INSTR_FETCH_CYCLE_COUNT_EN
        exp_cnt10 = 32'd10;
`else
        exp_cnt10 = 32'd0;
`endif
        Reset_n = 1'b0; StartAddr = '0; Target = '0;
        idle_inputs();
        step(); step();
        check("rst_ra",    32'(ReadAddress), 32'h0);
        check("rst_valid", 32'(InstrValid),  32'h0);
        check("rst_out",   32'(InstrOut),    32'h0);
        check("rst_busy",  32'(Busy),        32'h0);
        check("rst_done",  32'(Done),        32'h0);
        check("rst_cnt",   CycleCount,       32'h0);

        // Start at 0x10 and fetch three words
        Reset_n = 1'b1; Start = 1'b1; StartAddr = 16'h0010;
        step(); Start = 1'b0;
        check("start_ra",    32'(ReadAddress), 32'h10);
        check("start_valid", 32'(InstrValid),  32'h0);
        check("start_busy",  32'(Busy),        32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_out", 32'(InstrOut),    32'(i + 1));
            check("seq_pc",  32'(InstrPC),     32'h10 + 32'(i));
            check("seq_vld", 32'(InstrValid),  32'h1);
            check("seq_ra",  32'(ReadAddress), 32'h11 + 32'(i));
        end

        // Branch to 0x20, then from 0x20 to 0x100
        Branch = 1'b1; Target = 16'h0020;
        step();
        check("br1_ra",  32'(ReadAddress), 32'h20);
        check("br1_vld", 32'(InstrValid),  32'h0);
        check("br1_out", 32'(InstrOut),    32'h3);
        check("br1_pc",  32'(InstrPC),     32'h12);
        Target = 16'h0100;
        step(); Branch = 1'b0;
        check("br2_ra",  32'(ReadAddress), 32'h100);
        check("br2_vld", 32'(InstrValid),  32'h0);
        step();
        check("br2_out", 32'(InstrOut),    32'(rom(16'h0100)));
        check("br2_pc",  32'(InstrPC),     32'h100);
        check("br2_v1",  32'(InstrValid),  32'h1);

        // Get to PC=0x30 with a valid word from 0x2F, then stall 3 cycles
        Branch = 1'b1; Target = 16'h002F;
        step(); Branch = 1'b0;
        step();
        check("pre_stall_ra", 32'(ReadAddress), 32'h30);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ra",  32'(ReadAddress), 32'h30);
            check("stall_out", 32'(InstrOut),    32'(rom(16'h002F)));
            check("stall_pc",  32'(InstrPC),     32'h2F);
            check("stall_vld", 32'(InstrValid),  32'h1);
        end
        Stall = 1'b0;
        step();
        check("resume_ra",  32'(ReadAddress), 32'h31);
        check("resume_out", 32'(InstrOut),    32'(rom(16'h0030)));
        check("resume_pc",  32'(InstrPC),     32'h30);
        Stall = 1'b1; Branch = 1'b1; Target = 16'h0200;
        step(); idle_inputs();
        check("brstall_ra",  32'(ReadAddress), 32'h200);
        check("brstall_vld", 32'(InstrValid),  32'h0);

        // Start while running is ignored
        Start = 1'b1; StartAddr = 16'h0555;
        step(); Start = 1'b0;
        check("start_ign_ra", 32'(ReadAddress), 32'h201);
        check("start_ign_vld", 32'(InstrValid), 32'h1);

        // Halt + Branch: halt wins, PC frozen
        Halt = 1'b1; Branch = 1'b1; Target = 16'h0300;
        step(); idle_inputs();
        check("halt_done", 32'(Done),        32'h1);
        check("halt_busy", 32'(Busy),        32'h0);
        check("halt_vld",  32'(InstrValid),  32'h0);
        check("halt_ra",   32'(ReadAddress), 32'h201);
        Branch = 1'b1; Halt = 1'b1; Stall = 1'b1; Target = 16'h0400;
        step(); idle_inputs();
        check("halted_ign_ra",   32'(ReadAddress), 32'h201);
        check("halted_ign_done", 32'(Done),        32'h1);

        // Wrap of the PC from 0xFFFE
        Start = 1'b1; StartAddr = 16'hFFFE;
        step(); Start = 1'b0;
        check("wrap_ra0", 32'(ReadAddress), 32'hFFFE);
        check("wrap_busy", 32'(Busy), 32'h1);
        step();
        check("wrap_ra1", 32'(ReadAddress), 32'hFFFF);
        check("wrap_pc1", 32'(InstrPC),     32'hFFFE);
        step();
        check("wrap_ra2", 32'(ReadAddress), 32'h0000);
        check("wrap_pc2", 32'(InstrPC),     32'hFFFF);

        // Counter: halt, restart, 9 RUN cycles (2 stalls) then halt cycle
        Halt = 1'b1;
        step(); Halt = 1'b0;
        Start = 1'b1; StartAddr = 16'h0050;
        step(); Start = 1'b0;
        check("cnt_clr", CycleCount, 32'h0);
        for (int i = 0; i < 9; i++) begin
            Stall = (i == 3 || i == 6);
            step();
        end
        Stall = 1'b0; Halt = 1'b1;
        step(); Halt = 1'b0;
        check("cnt_ra",   32'(ReadAddress), 32'h57);
        check("cnt_10",   CycleCount, exp_cnt10);
        step(); step();
        check("cnt_hold", CycleCount, exp_cnt10);
        check("cnt_done", 32'(Done),  32'h1);
        Start = 1'b1; StartAddr = 16'h0044;
        step(); Start = 1'b0;
        check("cnt_restart", CycleCount, 32'h0);
        check("pre_rst_ra",  32'(ReadAddress), 32'h44);

        // Reset mid-RUN with a simultaneous Start
        Reset_n = 1'b0; Start = 1'b1; StartAddr = 16'h0099;
        step();
        check("mrst_ra",   32'(ReadAddress), 32'h0);
        check("mrst_busy", 32'(Busy),        32'h0);
        check("mrst_vld",  32'(InstrValid),  32'h0);
        check("mrst_out",  32'(InstrOut),    32'h0);
        check("mrst_cnt",  CycleCount,       32'h0);
        Reset_n = 1'b1; Start = 1'b0; Branch = 1'b1; Halt = 1'b1; Target = 16'h0077;
        step(); idle_inputs();
        check("idle_ign_ra",   32'(ReadAddress), 32'h0);
        check("idle_ign_busy", 32'(Busy),        32'h0);
        check("idle_ign_done", 32'(Done),        32'h0);
        Start = 1'b1; StartAddr = 16'h0005;
        step(); Start = 1'b0;
        check("restart_ra",   32'(ReadAddress), 32'h5);
        check("restart_busy", 32'(Busy),        32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_size, 16, width of program counter and ROM address, SHALL be supported.
REQ-002 Parameter DW, 9, instruction width, SHALL be supported.
REQ-003 CLK  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 Reset_n  input  1  reset, synchronous, active-low.
REQ-005 Start  input  1  one-cycle pulse; begin fetching at StartAddr.
REQ-006 StartAddr  input  PC_size  program entry address.
REQ-007 Stall  input  1  hold PC and fetched instruction.
REQ-008 Branch  input  1  redirect fetch to Target (taken branch/jump from decode).
REQ-009 Target  input  PC_size  absolute redirect address.
REQ-010 Halt  input  1  stop fetching (decoded halt instruction).
REQ-011 ReadAddress  output  PC_size  address to instruction ROM, equal to PC.
REQ-012 Instruction  input  DW  combinational ROM data for ReadAddress.
REQ-013 InstrOut  output  DW  registered instruction to decode.
REQ-014 InstrPC  output  PC_size  address InstrOut was fetched from.
REQ-015 InstrValid  output  1  InstrOut is a live, non-squashed instruction.
REQ-016 Busy  output  1  high in RUN.
REQ-017 Done  output  1  high in HALTED.
REQ-018 CycleCount  output  32  RUN-cycle count (see Configuration).

Function
REQ-019 States IDLE, RUN, HALTED; reset state IDLE.
REQ-020 IDLE/HALTED + Start: PC <= StartAddr, InstrValid <= 0, next state RUN; Start in RUN SHALL be ignored.
REQ-021 RUN, no Halt/Branch/Stall: InstrOut <= Instruction, InstrPC <= PC, InstrValid <= 1, PC <= PC+1 (one-cycle fetch latency).
REQ-022 PC increment SHALL wrap modulo 2**PC_size (all-ones -> 0) with no flag.
REQ-023 RUN + Branch: PC <= Target, InstrValid <= 0 (wrong-path fetch squashed, exactly one bubble); InstrOut/InstrPC SHALL hold.
REQ-024 RUN + Stall (no Branch/Halt): PC, InstrOut, InstrPC, InstrValid SHALL hold.
REQ-025 RUN + Halt: next state HALTED, InstrValid <= 0, PC holds.
REQ-026 Priority when simultaneous: Halt > Branch > Stall.
REQ-027 Branch, Stall, Halt SHALL be ignored in IDLE and HALTED.
REQ-028 Busy and Done SHALL be decoded from registered state only (no input-to-output combinational path); ReadAddress SHALL be PC directly.

Reset
REQ-029 Reset_n low at an edge: state IDLE, PC 0, InstrOut 0, InstrPC 0, InstrValid 0, CycleCount 0, regardless of state or simultaneous inputs.
REQ-030 Reset mid-RUN SHALL discard the in-flight fetch; no Start is honoured in the reset cycle.

Configuration
REQ-031 Macro INSTR_FETCH_CYCLE_COUNT_EN defined: CycleCount cleared on accepted Start, +1 each RUN cycle (stall and bubble cycles included), saturates at 0xFFFFFFFF, holds in IDLE/HALTED.
REQ-032 Macro undefined: CycleCount SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-033 Reset, Start with StartAddr=0x0010, ROM[0x10..0x12]=0x001,0x002,0x003 -> ReadAddress 0x10,0x11,0x12; InstrOut 0x001/0x002/0x003 with InstrPC 0x10/0x11/0x12, each one cycle after address.
REQ-034 In RUN at PC=0x0020, Branch=1 Target=0x0100 -> next cycle InstrValid=0, ReadAddress=0x0100; following cycle InstrOut=ROM[0x100], InstrPC=0x0100, InstrValid=1.
REQ-035 Stall held 3 cycles at PC=0x0030 -> ReadAddress, InstrOut, InstrPC unchanged for 3 cycles; resumes at 0x0031 after release; Branch+Stall same cycle -> redirect taken.
REQ-036 Start at StartAddr=0xFFFE -> ReadAddress 0xFFFE,0xFFFF,0x0000; Halt+Branch same cycle -> Done=1, Busy=0, InstrValid=0, PC unchanged.
REQ-037 With INSTR_FETCH_CYCLE_COUNT_EN: Start, 10 RUN cycles incl. 2 stalls, Halt -> CycleCount=10 held; new Start clears to 0; without macro CycleCount=0 throughout.
REQ-038 Reset_n low mid-RUN at PC=0x0044 -> next cycle PC=0, state IDLE, InstrValid=0; Branch/Halt ignored until Start.
